// File: rtl/traffic_light_ctrl_param.sv
// Four-approach intersection controller (M1, M2, MT, S) with parametrised
// phase lengths, a tick prescaler, a latched pedestrian request with an
// acknowledge pulse, and emergency pre-emption.
//
// state  | code | meaning
// -------+------+-----------------------------------------------
// ALLRED |  0   | all approaches red, decides next phase
// MAIN   |  1   | M1 and M2 green
// M2_Y   |  2   | M1 green, M2 yellow
// TURN   |  3   | M1 and MT green
// TURN_Y |  4   | M1 and MT yellow
// SIDE   |  5   | S green
// SIDE_Y |  6   | S yellow
// PED    |  7   | all red, pedestrian walk
// EM_Y   |  8   | M1 and M2 yellow on the way to EMERG
// EMERG  |  9   | all red while emergency is active

module traffic_light_ctrl_param #(
    parameter int unsigned TICK_DIV = 1,
    parameter int unsigned T_MAIN   = 10,
    parameter int unsigned T_TURN   = 5,
    parameter int unsigned T_SIDE   = 5,
    parameter int unsigned T_YEL    = 3,
    parameter int unsigned T_ALLRED = 1,
    parameter int unsigned T_PED    = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ped_req,
    input  logic       emerg,
    output logic [2:0] light_M1,
    output logic [2:0] light_M2,
    output logic [2:0] light_MT,
    output logic [2:0] light_S,
    output logic       ped_walk,
    output logic       ped_ack,
    output logic [3:0] phase
);

    typedef enum logic [3:0] {
        S_ALLRED = 4'd0,
        S_MAIN   = 4'd1,
        S_M2_Y   = 4'd2,
        S_TURN   = 4'd3,
        S_TURN_Y = 4'd4,
        S_SIDE   = 4'd5,
        S_SIDE_Y = 4'd6,
        S_PED    = 4'd7,
        S_EM_Y   = 4'd8,
        S_EMERG  = 4'd9
    } state_e;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    localparam logic [CNT_W-1:0] DIV_LAST    = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] MAIN_LAST   = CNT_W'(T_MAIN - 1);
    localparam logic [CNT_W-1:0] TURN_LAST   = CNT_W'(T_TURN - 1);
    localparam logic [CNT_W-1:0] SIDE_LAST   = CNT_W'(T_SIDE - 1);
    localparam logic [CNT_W-1:0] YEL_LAST    = CNT_W'(T_YEL - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] PED_LAST    = CNT_W'(T_PED - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0] tick_q, tick_d;
    logic             pend_q, pend_d;
    logic             ack_q, ack_d;

    logic [CNT_W-1:0] tick_last;
    logic             expired;
    logic             ped_enter;

    // Last tick index of the current state's duration
    always_comb begin
        tick_last = '0;
        case (state_q)
            S_ALLRED: tick_last = ALLRED_LAST;
            S_MAIN:   tick_last = MAIN_LAST;
            S_M2_Y:   tick_last = YEL_LAST;
            S_TURN:   tick_last = TURN_LAST;
            S_TURN_Y: tick_last = YEL_LAST;
            S_SIDE:   tick_last = SIDE_LAST;
            S_SIDE_Y: tick_last = YEL_LAST;
            S_PED:    tick_last = PED_LAST;
            S_EM_Y:   tick_last = YEL_LAST;
            default:  tick_last = '0;
        endcase
    end

    assign expired = (presc_q == DIV_LAST) && (tick_q == tick_last);

    // Next-state selection; emergency pre-empts green phases through a yellow
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ALLRED: begin
                if (emerg)        state_d = S_EMERG;
                else if (expired) state_d = pend_q ? S_PED : S_MAIN;
            end
            S_MAIN: begin
                if (emerg)        state_d = S_EM_Y;
                else if (expired) state_d = S_M2_Y;
            end
            S_M2_Y: begin
                if (emerg)        state_d = S_EM_Y;
                else if (expired) state_d = S_TURN;
            end
            S_TURN: begin
                if (emerg || expired) state_d = S_TURN_Y;
            end
            S_TURN_Y: begin
                if (expired) state_d = emerg ? S_EMERG : S_SIDE;
            end
            S_SIDE: begin
                if (emerg || expired) state_d = S_SIDE_Y;
            end
            S_SIDE_Y: begin
                if (expired) state_d = emerg ? S_EMERG : S_ALLRED;
            end
            S_PED: begin
                if (emerg)        state_d = S_EMERG;
                else if (expired) state_d = S_ALLRED;
            end
            S_EM_Y: begin
                if (expired) state_d = emerg ? S_EMERG : S_ALLRED;
            end
            S_EMERG: begin
                if (!emerg) state_d = S_ALLRED;
            end
            default: state_d = S_ALLRED;
        endcase
    end

    // Prescaler and tick counter; cleared on any state change, idle in EMERG
    always_comb begin
        presc_d = presc_q;
        tick_d  = tick_q;
        if ((state_d != state_q) || (state_q == S_EMERG)) begin
            presc_d = '0;
            tick_d  = '0;
        end else if (presc_q == DIV_LAST) begin
            presc_d = '0;
            tick_d  = tick_q + 1'b1;
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    // Pending request: a request on the PED entry edge survives the clear
    assign ped_enter = (state_d == S_PED) && (state_q != S_PED);

    always_comb begin
        pend_d = pend_q;
        ack_d  = ped_enter;
        if (ped_enter) pend_d = 1'b0;
        if (ped_req)   pend_d = 1'b1;
    end

    // State, counter and handshake registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_ALLRED;
            presc_q <= '0;
            tick_q  <= '0;
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
        end
    end

    // Moore lamp decode from the state register
    always_comb begin
        light_M1 = LAMP_R;
        light_M2 = LAMP_R;
        light_MT = LAMP_R;
        light_S  = LAMP_R;
        ped_walk = 1'b0;
        case (state_q)
            S_MAIN: begin
                light_M1 = LAMP_G;
                light_M2 = LAMP_G;
            end
            S_M2_Y: begin
                light_M1 = LAMP_G;
                light_M2 = LAMP_Y;
            end
            S_TURN: begin
                light_M1 = LAMP_G;
                light_MT = LAMP_G;
            end
            S_TURN_Y: begin
                light_M1 = LAMP_Y;
                light_MT = LAMP_Y;
            end
            S_SIDE:   light_S = LAMP_G;
            S_SIDE_Y: light_S = LAMP_Y;
            S_PED:    ped_walk = 1'b1;
            S_EM_Y: begin
                light_M1 = LAMP_Y;
                light_M2 = LAMP_Y;
            end
            default: ;
        endcase
    end

    assign ped_ack = ack_q;
    assign phase   = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl_param.sv
module tb_traffic_light_ctrl_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       ped_req;
    logic       emerg;
    logic [2:0] light_M1, light_M2, light_MT, light_S;
    logic       ped_walk, ped_ack;
    logic [3:0] phase;

    int total = 0;
    int bad   = 0;

    localparam logic [3:0] ALLRED = 4'd0, MAIN = 4'd1, M2_Y = 4'd2, TURN = 4'd3,
                           TURN_Y = 4'd4, SIDE = 4'd5, SIDE_Y = 4'd6, PED = 4'd7,
                           EM_Y = 4'd8, EMERG = 4'd9;

    traffic_light_ctrl_param #(
        .TICK_DIV(2), .T_MAIN(4), .T_TURN(3), .T_SIDE(3),
        .T_YEL(2), .T_ALLRED(1), .T_PED(2), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .ped_req(ped_req), .emerg(emerg),
        .light_M1(light_M1), .light_M2(light_M2), .light_MT(light_MT), .light_S(light_S),
        .ped_walk(ped_walk), .ped_ack(ped_ack), .phase(phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       emerg;
        logic       ped;
        logic [3:0] ph;
        int         n;
        logic [11:0] lamps;
    } vec_t;

    typedef struct {
        logic [3:0]  ph;
        logic [11:0] lamps;
        logic        walk;
        logic        ack;
    } exp_t;

    exp_t       sbq[$];
    logic [3:0] prev_ph;

    function automatic logic [11:0] lamp_of(input logic [3:0] p);
        case (p)
            MAIN:   return 12'b001_001_100_100;
            M2_Y:   return 12'b001_010_100_100;
            TURN:   return 12'b001_100_001_100;
            TURN_Y: return 12'b010_100_010_100;
            SIDE:   return 12'b100_100_100_001;
            SIDE_Y: return 12'b100_100_100_010;
            EM_Y:   return 12'b010_010_100_100;
            default: return 12'b100_100_100_100;
        endcase
    endfunction

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] p, input logic [11:0] lamps);
        exp_t e;
        e.ph    = p;
        e.lamps = lamps;
        e.walk  = (p == PED);
        e.ack   = (p == PED) && (prev_ph != PED);
        prev_ph = p;
        sbq.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
            e = sbq.pop_front();
            chk("phase", 12'(phase), 12'(e.ph));
            chk("lamps", {light_M1, light_M2, light_MT, light_S}, e.lamps);
            chk("ped_walk", 12'(ped_walk), 12'(e.walk));
            chk("ped_ack", 12'(ped_ack), 12'(e.ack));
        end
    endtask

    task automatic seg(input logic [3:0] p, input int n);
        for (int i = 0; i < n; i++) begin
            push(p, lamp_of(p));
            step();
        end
    endtask

    // Safety invariants sampled mid-cycle
    logic [11:0] prev_l = 12'b100_100_100_100;
    always @(negedge clk) begin
        logic [11:0] cur;
        cur = {light_M1, light_M2, light_MT, light_S};
        total++;
        if ((light_M2 == 3'b001 && light_MT == 3'b001) || (light_M2 == 3'b001 && light_S == 3'b001) ||
            (light_MT == 3'b001 && light_S == 3'b001) || (light_M1 == 3'b001 && light_S == 3'b001)) begin
            bad++;
            $display("FAIL conflict_green: got %b at %0t", cur, $time);
        end
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (prev_l[k*3 +: 3] == 3'b001 && cur[k*3 +: 3] == 3'b100) begin
                    bad++;
                    $display("FAIL green_to_red lamp%0d: got %b from %b at %0t", k, cur, prev_l, $time);
                end
            end
        end
        prev_l = cur;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    vec_t tbl[15];

    initial begin
        tbl[0]  = '{1'b0, 1'b0, ALLRED, 1, 12'b100_100_100_100};
        tbl[1]  = '{1'b0, 1'b0, MAIN,   8, 12'b001_001_100_100};
        tbl[2]  = '{1'b0, 1'b0, M2_Y,   4, 12'b001_010_100_100};
        tbl[3]  = '{1'b0, 1'b0, TURN,   6, 12'b001_100_001_100};
        tbl[4]  = '{1'b0, 1'b0, TURN_Y, 4, 12'b010_100_010_100};
        tbl[5]  = '{1'b0, 1'b0, SIDE,   6, 12'b100_100_100_001};
        tbl[6]  = '{1'b0, 1'b0, SIDE_Y, 4, 12'b100_100_100_010};
        tbl[7]  = '{1'b0, 1'b0, ALLRED, 2, 12'b100_100_100_100};
        tbl[8]  = '{1'b0, 1'b0, MAIN,   8, 12'b001_001_100_100};
        tbl[9]  = '{1'b0, 1'b0, M2_Y,   4, 12'b001_010_100_100};
        tbl[10] = '{1'b0, 1'b0, TURN,   6, 12'b001_100_001_100};
        tbl[11] = '{1'b0, 1'b0, TURN_Y, 4, 12'b010_100_010_100};
        tbl[12] = '{1'b0, 1'b0, SIDE,   6, 12'b100_100_100_001};
        tbl[13] = '{1'b0, 1'b0, SIDE_Y, 4, 12'b100_100_100_010};
        tbl[14] = '{1'b0, 1'b0, ALLRED, 2, 12'b100_100_100_100};

        rst = 1'b1; emerg = 1'b0; ped_req = 1'b0; prev_ph = ALLRED;
        #12;
        chk("reset_phase", 12'(phase), 12'd0);
        chk("reset_lamps", {light_M1, light_M2, light_MT, light_S}, 12'b100_100_100_100);
        chk("reset_walk", 12'(ped_walk), 12'd0);
        chk("reset_ack", 12'(ped_ack), 12'd0);
        @(posedge clk); #1; rst = 1'b0;

        // Two full 34-cycle periods from the table
        for (int v = 0; v < 15; v++) begin
            emerg   = tbl[v].emerg;
            ped_req = tbl[v].ped;
            for (int i = 0; i < tbl[v].n; i++) begin
                push(tbl[v].ph, tbl[v].lamps);
                step();
            end
        end

        // Pedestrian pulse during TURN, single PED afterwards
        seg(MAIN, 8); seg(M2_Y, 4); seg(TURN, 2);
        ped_req = 1'b1; seg(TURN, 1); ped_req = 1'b0;
        seg(TURN, 3); seg(TURN_Y, 4); seg(SIDE, 6); seg(SIDE_Y, 4);
        seg(ALLRED, 2); seg(PED, 4); seg(ALLRED, 2);

        // Emergency at MAIN cycle 3
        seg(MAIN, 3);
        emerg = 1'b1; seg(EM_Y, 4); seg(EMERG, 5);
        emerg = 1'b0; seg(ALLRED, 2);

        // Emergency at SIDE cycle 1: yellow runs full length
        seg(MAIN, 8); seg(M2_Y, 4); seg(TURN, 6); seg(TURN_Y, 4); seg(SIDE, 1);
        emerg = 1'b1; seg(SIDE_Y, 4); seg(EMERG, 3);
        emerg = 1'b0; seg(ALLRED, 2);

        // Request on the PED entry edge stays pending; then emergency in PED
        seg(MAIN, 1); ped_req = 1'b1; seg(MAIN, 1); ped_req = 1'b0;
        seg(MAIN, 6); seg(M2_Y, 4); seg(TURN, 6); seg(TURN_Y, 4); seg(SIDE, 6); seg(SIDE_Y, 4);
        seg(ALLRED, 2);
        ped_req = 1'b1; seg(PED, 1); ped_req = 1'b0;
        seg(PED, 3); seg(ALLRED, 2); seg(PED, 2);
        emerg = 1'b1; seg(EMERG, 3);
        emerg = 1'b0; seg(ALLRED, 2);

        // Asynchronous reset mid-SIDE
        seg(MAIN, 8); seg(M2_Y, 4); seg(TURN, 6); seg(TURN_Y, 4); seg(SIDE, 3);
        #2; rst = 1'b1;
        #1;
        chk("async_rst_phase", 12'(phase), 12'd0);
        chk("async_rst_lamps", {light_M1, light_M2, light_MT, light_S}, 12'b100_100_100_100);
        chk("async_rst_walk", 12'(ped_walk), 12'd0);
        #20;
        @(posedge clk); #1; rst = 1'b0; prev_ph = ALLRED;
        seg(ALLRED, 1); seg(MAIN, 8); seg(M2_Y, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
